// File: rtl/al_accel_cp_array_if.sv
// Bus bundle for al_accel_cp_array: window input stream, mode bits and the pooled result.
// AL_ACCEL_CP_ARGMAX_EN adds the per-channel winner index (cp_idx).
interface al_accel_cp_array_if #(
  parameter int DW  = 8,
  parameter int CH  = 4,
  parameter int WIN = 4,
  parameter int IW  = (WIN > 1) ? $clog2(WIN) : 1
);
  logic              en;
  logic              cp_clr;
  logic              cp_vi;
  logic [CH*DW-1:0]  cp_di;
  logic              cp_min;
  logic              cp_signed;
  logic [CH*DW-1:0]  cp_do;
  logic              cp_vo;
`ifdef AL_ACCEL_CP_ARGMAX_EN
  logic [CH*IW-1:0]  cp_idx;
`endif
  logic              cp_busy;

  modport master (
    output en, cp_clr, cp_vi, cp_di, cp_min, cp_signed,
`ifdef AL_ACCEL_CP_ARGMAX_EN
    input  cp_idx,
`endif
    input  cp_do, cp_vo, cp_busy
  );

  modport slave (
    input  en, cp_clr, cp_vi, cp_di, cp_min, cp_signed,
`ifdef AL_ACCEL_CP_ARGMAX_EN
    output cp_idx,
`endif
    output cp_do, cp_vo, cp_busy
  );
endinterface

// File: rtl/al_accel_cp_array.sv
// Multi-channel max/min pooling over WIN consecutive valid vectors, signed or unsigned ordering.
// Define AL_ACCEL_CP_ARGMAX_EN to keep the per-channel winner index (aidx / cp_idx).
module al_accel_cp_array #(
  parameter int DW  = 8,
  parameter int CH  = 4,
  parameter int WIN = 4,
  parameter int IW  = (WIN > 1) ? $clog2(WIN) : 1
) (
  input  logic              clk,
  input  logic              reset,
  al_accel_cp_array_if.slave cp
);

  localparam logic [IW-1:0] LAST = IW'(WIN - 1);

  logic [IW-1:0]    cnt;
  logic [DW-1:0]    acc [CH];
  logic             m_min;
  logic             m_sgn;
  logic [DW-1:0]    win_val [CH];
  logic [CH*DW-1:0] do_p1;
  logic             vo_p1;
  logic             accept;
  logic             first;
  logic             last;
`ifdef AL_ACCEL_CP_ARGMAX_EN
  logic [IW-1:0]    aidx [CH];
  logic [IW-1:0]    win_idx [CH];
  logic [CH*IW-1:0] idx_p1;
`endif

  // Strictly-better test; sign- or zero-extend to DW+1 so one signed compare covers both orderings.
  function automatic logic is_better(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                     input logic mn, input logic sg);
    logic signed [DW:0] ea;
    logic signed [DW:0] eb;
    ea = sg ? $signed({a[DW-1], a}) : $signed({1'b0, a});
    eb = sg ? $signed({b[DW-1], b}) : $signed({1'b0, b});
    return mn ? (ea < eb) : (ea > eb);
  endfunction

  assign accept = cp.en && cp.cp_vi && !cp.cp_clr;
  assign first  = (cnt == '0);
  assign last   = (cnt == LAST);

  // Stage p0: candidate winner per channel given the accumulator and the incoming element
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      win_val[c] = acc[c];
`ifdef AL_ACCEL_CP_ARGMAX_EN
      win_idx[c] = aidx[c];
`endif
      if (first) begin
        win_val[c] = cp.cp_di[c*DW +: DW];
`ifdef AL_ACCEL_CP_ARGMAX_EN
        win_idx[c] = '0;
`endif
      end else if (is_better(cp.cp_di[c*DW +: DW], acc[c], m_min, m_sgn)) begin
        win_val[c] = cp.cp_di[c*DW +: DW];
`ifdef AL_ACCEL_CP_ARGMAX_EN
        win_idx[c] = cnt;
`endif
      end
    end
  end

  // Stage p1: window state and registered result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      m_min <= 1'b0;
      m_sgn <= 1'b0;
      do_p1 <= '0;
      vo_p1 <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        acc[c] <= '0;
`ifdef AL_ACCEL_CP_ARGMAX_EN
        aidx[c] <= '0;
`endif
      end
`ifdef AL_ACCEL_CP_ARGMAX_EN
      idx_p1 <= '0;
`endif
    end else if (!cp.en) begin
      vo_p1 <= 1'b0;
    end else if (cp.cp_clr) begin
      cnt   <= '0;
      vo_p1 <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        acc[c] <= '0;
`ifdef AL_ACCEL_CP_ARGMAX_EN
        aidx[c] <= '0;
`endif
      end
    end else if (accept) begin
      for (int c = 0; c < CH; c++) begin
        acc[c] <= win_val[c];
`ifdef AL_ACCEL_CP_ARGMAX_EN
        aidx[c] <= win_idx[c];
`endif
      end
      if (first) begin
        m_min <= cp.cp_min;
        m_sgn <= cp.cp_signed;
      end
      if (last) begin
        cnt   <= '0;
        vo_p1 <= 1'b1;
        for (int c = 0; c < CH; c++) begin
          do_p1[c*DW +: DW] <= win_val[c];
`ifdef AL_ACCEL_CP_ARGMAX_EN
          idx_p1[c*IW +: IW] <= win_idx[c];
`endif
        end
      end else begin
        cnt   <= cnt + IW'(1);
        vo_p1 <= 1'b0;
      end
    end else begin
      vo_p1 <= 1'b0;
    end
  end

  assign cp.cp_do   = do_p1;
  assign cp.cp_vo   = vo_p1;
  assign cp.cp_busy = (cnt != '0);
`ifdef AL_ACCEL_CP_ARGMAX_EN
  assign cp.cp_idx  = idx_p1;
`endif

endmodule
